stage_mem_hs: RTL and testbench

Parametrised pipeline memory stage for the in-order core. It replaces the fixed single-cycle memory stage with one that talks to data memory over a req/gnt/rvalid handshake.
- Supports byte, half and word accesses with byte enables and sign/zero extension.
- Detects misaligned accesses and bounds memory waits with a timeout.
- Sits between the EX and WB stages, with valid/ready on both sides so it can stall the pipeline.

---
 rtl/stage_mem_hs_pkg.sv | 38 +++
 rtl/stage_mem_hs_if.sv | 58 +++++
 rtl/stage_mem_hs_lane_align.sv | 40 ++++
 rtl/stage_mem_hs.sv | 143 ++++++++++++++
 tb/tb_stage_mem_hs.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/stage_mem_hs_pkg.sv
// Shared types and lane helpers for the handshaked memory stage.
package stage_mem_hs_pkg;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        HALF  = 2'd1,
        WORD  = 2'd2,
        DWORD = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        OUT  = 2'd3
    } mem_state_e;

    // Byte-enable mask for an access of the given size starting at byte offset.
    function automatic logic [7:0] be_mask(input mem_size_e size, input logic [2:0] offset);
        logic [7:0] m;
        case (size)
            BYTE:    m = 8'h01;
            HALF:    m = 8'h03;
            WORD:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << offset;
    endfunction

    // Offset not a multiple of the access size, or size wider than the bus.
    function automatic logic misaligned(input mem_size_e size, input logic [2:0] offset,
                                        input int nb);
        logic [3:0] bytes;
        bytes = 4'd1 << size;
        return ((offset & 3'(bytes - 4'd1)) != 3'd0) || (int'(bytes) > nb);
    endfunction

endpackage

// File: rtl/stage_mem_hs_if.sv
// EX-side, WB-side and data-memory signals of the memory stage.
interface stage_mem_hs_if #(
    parameter int WD_SIZE        = 32,
    parameter int INSTR_SIZE     = 32,
    parameter int INSTR_REG_BITS = 5
);
    logic                      in_valid;
    logic                      in_ready;
    logic [INSTR_SIZE-1:0]     pc_i;
    logic [INSTR_REG_BITS-1:0] rd_i;
    logic [WD_SIZE-1:0]        alu_result_i;
    logic [WD_SIZE-1:0]        rs2_data_i;
    logic                      instr_ld_i;
    logic                      instr_st_i;
    logic                      instr_jm_i;
    logic                      instr_br_i;
    logic [1:0]                mem_size_i;
    logic                      mem_unsigned_i;

    logic                      out_valid;
    logic                      out_ready;
    logic [INSTR_SIZE-1:0]     pc_o;
    logic [INSTR_REG_BITS-1:0] rd_o;
    logic [WD_SIZE-1:0]        alu_result_o;
    logic                      instr_ld_o;
    logic                      instr_jm_o;
    logic                      instr_br_o;
    logic [WD_SIZE-1:0]        rd_data_o;
    logic                      misalign_o;
    logic                      bus_err_o;

    logic                      mem_req;
    logic                      mem_gnt;
    logic [WD_SIZE-1:0]        mem_addr;
    logic                      mem_we;
    logic [WD_SIZE/8-1:0]      mem_be;
    logic [WD_SIZE-1:0]        mem_wdata;
    logic                      mem_rvalid;
    logic [WD_SIZE-1:0]        mem_rdata;

    modport master (
        output in_valid, pc_i, rd_i, alu_result_i, rs2_data_i, instr_ld_i, instr_st_i,
               instr_jm_i, instr_br_i, mem_size_i, mem_unsigned_i, out_ready,
               mem_gnt, mem_rvalid, mem_rdata,
        input  in_ready, out_valid, pc_o, rd_o, alu_result_o, instr_ld_o, instr_jm_o,
               instr_br_o, rd_data_o, misalign_o, bus_err_o,
               mem_req, mem_addr, mem_we, mem_be, mem_wdata
    );

    modport slave (
        input  in_valid, pc_i, rd_i, alu_result_i, rs2_data_i, instr_ld_i, instr_st_i,
               instr_jm_i, instr_br_i, mem_size_i, mem_unsigned_i, out_ready,
               mem_gnt, mem_rvalid, mem_rdata,
        output in_ready, out_valid, pc_o, rd_o, alu_result_o, instr_ld_o, instr_jm_o,
               instr_br_o, rd_data_o, misalign_o, bus_err_o,
               mem_req, mem_addr, mem_we, mem_be, mem_wdata
    );
endinterface

// File: rtl/stage_mem_hs_lane_align.sv
// Byte-lane steering: store shift + byte enables, load extract + sign/zero extend.
// Latency: combinational.
// Backpressure: none, pure datapath.
module mem_lane_align
    import stage_mem_hs_pkg::*;
#(
    parameter int WD_SIZE = 32
) (
    input  mem_size_e                    size,
    input  logic [$clog2(WD_SIZE/8)-1:0] offset,
    input  logic                         is_unsigned,
    input  logic [WD_SIZE-1:0]           st_data,
    input  logic [WD_SIZE-1:0]           ld_raw,
    output logic [WD_SIZE/8-1:0]         be,
    output logic [WD_SIZE-1:0]           st_lane,
    output logic [WD_SIZE-1:0]           ld_data
);
    localparam int NB = WD_SIZE / 8;

    logic [7:0]         be_full;
    logic [WD_SIZE-1:0] ld_shift;

    assign be_full  = be_mask(size, 3'(offset));
    assign be       = be_full[NB-1:0];
    assign st_lane  = st_data << {offset, 3'b000};
    assign ld_shift = ld_raw >> {offset, 3'b000};

    always_comb begin
        ld_data = ld_shift;
        case (size)
            BYTE: ld_data = is_unsigned ? WD_SIZE'(ld_shift[7:0])
                                        : WD_SIZE'($signed(ld_shift[7:0]));
            HALF: ld_data = is_unsigned ? WD_SIZE'(ld_shift[15:0])
                                        : WD_SIZE'($signed(ld_shift[15:0]));
            WORD: ld_data = is_unsigned ? WD_SIZE'(ld_shift[31:0])
                                        : WD_SIZE'($signed(ld_shift[31:0]));
            default: ld_data = ld_shift;
        endcase
    end
endmodule

// File: rtl/stage_mem_hs.sv
// Pipeline memory stage between EX and WB with a req/gnt/rvalid data-memory port.
// Latency: 1 cycle for non-memory/misaligned, 1 after gnt for stores, 1 after rvalid for loads.
// Backpressure: in_ready only in IDLE or when WB pops OUT; result held until out_ready.
module stage_mem_hs
    import stage_mem_hs_pkg::*;
#(
    parameter int WD_SIZE        = 32,
    parameter int INSTR_SIZE     = 32,
    parameter int INSTR_REG_BITS = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset,
    stage_mem_hs_if.slave bus
);
    localparam int NB   = WD_SIZE / 8;
    localparam int OFFW = $clog2(NB);
    localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    mem_state_e                state, state_nxt;
    logic [INSTR_SIZE-1:0]     pc_q;
    logic [INSTR_REG_BITS-1:0] rd_q;
    logic [WD_SIZE-1:0]        alu_q, rs2_q, rd_data_q;
    logic                      ld_q, st_q, jm_q, br_q, uns_q, misalign_q, bus_err_q;
    mem_size_e                 size_q;
    logic [TW-1:0]             tmo_cnt;

    logic                      in_ready_c, accept, in_misalign, in_mem, tmo_expire, tmo_hit;
    logic [NB-1:0]             lane_be;
    logic [WD_SIZE-1:0]        lane_wdata, lane_ld;

    assign in_misalign = (bus.instr_ld_i | bus.instr_st_i) &
                         misaligned(mem_size_e'(bus.mem_size_i), 3'(bus.alu_result_i[OFFW-1:0]), NB);
    assign in_mem      = (bus.instr_ld_i | bus.instr_st_i) & ~in_misalign;
    assign accept      = in_ready_c & bus.in_valid & ~reset;
    assign tmo_expire  = (TIMEOUT_CYCLES > 0) && (tmo_cnt == TMO_LAST);

    always_comb begin
        state_nxt  = state;
        in_ready_c = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            IDLE: in_ready_c = 1'b1;
            REQ: begin
                // A grant in the expiry cycle still completes the access.
                if (bus.mem_gnt) begin
                    state_nxt = st_q ? OUT : RSP;
                end else if (tmo_expire) begin
                    tmo_hit   = 1'b1;
                    state_nxt = OUT;
                end
            end
            RSP: begin
                if (bus.mem_rvalid) begin
                    state_nxt = OUT;
                end else if (tmo_expire) begin
                    tmo_hit   = 1'b1;
                    state_nxt = OUT;
                end
            end
            OUT: begin
                in_ready_c = bus.out_ready;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (accept) state_nxt = in_mem ? REQ : OUT;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= '0;
            rd_q       <= '0;
            alu_q      <= '0;
            rs2_q      <= '0;
            rd_data_q  <= '0;
            ld_q       <= 1'b0;
            st_q       <= 1'b0;
            jm_q       <= 1'b0;
            br_q       <= 1'b0;
            uns_q      <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            size_q     <= BYTE;
            tmo_cnt    <= '0;
        end else if (accept) begin
            pc_q       <= bus.pc_i;
            rd_q       <= bus.rd_i;
            alu_q      <= bus.alu_result_i;
            rs2_q      <= bus.rs2_data_i;
            ld_q       <= bus.instr_ld_i;
            st_q       <= bus.instr_st_i;
            jm_q       <= bus.instr_jm_i;
            br_q       <= bus.instr_br_i;
            uns_q      <= bus.mem_unsigned_i;
            size_q     <= mem_size_e'(bus.mem_size_i);
            rd_data_q  <= '0;
            misalign_q <= in_misalign;
            bus_err_q  <= 1'b0;
            tmo_cnt    <= '0;
        end else if (state == REQ || state == RSP) begin
            if (tmo_hit) bus_err_q <= 1'b1;
            if (state == RSP && bus.mem_rvalid) rd_data_q <= lane_ld;
            tmo_cnt <= (state_nxt != state) ? '0 : tmo_cnt + TW'(1);
        end
    end

    mem_lane_align #(.WD_SIZE(WD_SIZE)) u_lane (
        .size        (size_q),
        .offset      (alu_q[OFFW-1:0]),
        .is_unsigned (uns_q),
        .st_data     (rs2_q),
        .ld_raw      (bus.mem_rdata),
        .be          (lane_be),
        .st_lane     (lane_wdata),
        .ld_data     (lane_ld)
    );

    assign bus.in_ready     = in_ready_c & ~reset;
    assign bus.out_valid    = (state == OUT);
    assign bus.pc_o         = pc_q;
    assign bus.rd_o         = rd_q;
    assign bus.alu_result_o = alu_q;
    assign bus.instr_ld_o   = ld_q;
    assign bus.instr_jm_o   = jm_q;
    assign bus.instr_br_o   = br_q;
    assign bus.rd_data_o    = rd_data_q;
    assign bus.misalign_o   = misalign_q;
    assign bus.bus_err_o    = bus_err_q;

    // Memory port is quiet outside REQ so nothing leaks from stale captures.
    assign bus.mem_req   = (state == REQ);
    assign bus.mem_addr  = bus.mem_req ? (alu_q & ~WD_SIZE'(NB - 1)) : '0;
    assign bus.mem_we    = bus.mem_req & st_q;
    assign bus.mem_be    = bus.mem_req ? lane_be : '0;
    assign bus.mem_wdata = bus.mem_req ? lane_wdata : '0;
endmodule

// File: tb/tb_stage_mem_hs.sv
// Directed vector bench for stage_mem_hs with a small req/gnt/rvalid memory responder.
module tb_stage_mem_hs;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    stage_mem_hs_if #(.WD_SIZE(32), .INSTR_SIZE(32), .INSTR_REG_BITS(5)) bus ();

    stage_mem_hs #(
        .WD_SIZE(32), .INSTR_SIZE(32), .INSTR_REG_BITS(5), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        ld, st, jm, br;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr, rs2, rdata;
        int          gnt_dly, hold;
        int          e_lat, e_req;
        logic [31:0] e_maddr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata, e_rd;
        logic        e_mis, e_err;
    } vec_t;

    vec_t vecs[15];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          req_cnt, lat, c;
        logic        seen, stable, rv_pend;
        logic [31:0] a0, w0;
        logic [3:0]  b0;
        logic        we0;
        string       p;
        p = $sformatf("v%0d_", idx);
        bus.in_valid       = 1'b1;
        bus.pc_i           = 32'h1000 + 32'(idx * 4);
        bus.rd_i           = 5'(idx + 1);
        bus.alu_result_i   = v.addr;
        bus.rs2_data_i     = v.rs2;
        bus.instr_ld_i     = v.ld;
        bus.instr_st_i     = v.st;
        bus.instr_jm_i     = v.jm;
        bus.instr_br_i     = v.br;
        bus.mem_size_i     = v.size;
        bus.mem_unsigned_i = v.uns;
        bus.mem_rdata      = v.rdata;
        bus.mem_gnt        = 1'b0;
        bus.mem_rvalid     = 1'b0;
        bus.out_ready      = (v.hold == 0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        req_cnt = 0; lat = 0; c = 0;
        seen = 1'b0; stable = 1'b1; rv_pend = 1'b0;
        a0 = '0; w0 = '0; b0 = '0; we0 = 1'b0;
        while (!seen && c < 60) begin
            c++;
            bus.mem_rvalid = rv_pend;
            rv_pend = 1'b0;
            if (bus.out_valid) begin
                seen = 1'b1;
                lat = c;
                bus.mem_gnt = 1'b0;
            end else begin
                if (bus.mem_req) begin
                    if (req_cnt == 0) begin
                        a0 = bus.mem_addr; b0 = bus.mem_be; w0 = bus.mem_wdata; we0 = bus.mem_we;
                    end else if (bus.mem_addr !== a0 || bus.mem_be !== b0 ||
                                 bus.mem_wdata !== w0 || bus.mem_we !== we0) begin
                        stable = 1'b0;
                    end
                    req_cnt++;
                    bus.mem_gnt = (v.gnt_dly >= 0) && (req_cnt > v.gnt_dly);
                    rv_pend = bus.mem_gnt & v.ld;
                end else begin
                    bus.mem_gnt = 1'b0;
                end
                @(negedge clk);
            end
        end
        chk({p, "out_valid_seen"}, seen, 1);
        chk({p, "latency"}, lat, v.e_lat);
        chk({p, "req_cycles"}, req_cnt, v.e_req);
        if (v.e_req > 0) begin
            chk({p, "req_stable"}, stable, 1);
            chk({p, "mem_addr"}, a0, v.e_maddr);
            chk({p, "mem_be"}, b0, v.e_be);
            chk({p, "mem_wdata"}, w0, v.e_wdata);
            chk({p, "mem_we"}, we0, v.st);
        end
        chk({p, "rd_data_o"}, bus.rd_data_o, v.e_rd);
        chk({p, "misalign_o"}, bus.misalign_o, v.e_mis);
        chk({p, "bus_err_o"}, bus.bus_err_o, v.e_err);
        chk({p, "alu_result_o"}, bus.alu_result_o, v.addr);
        chk({p, "pc_o"}, bus.pc_o, 32'h1000 + 32'(idx * 4));
        chk({p, "rd_o"}, bus.rd_o, 5'(idx + 1));
        chk({p, "class_flags"}, {bus.instr_ld_o, bus.instr_jm_o, bus.instr_br_o},
            {v.ld, v.jm, v.br});
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk({p, "hold_out_valid"}, bus.out_valid, 1);
            chk({p, "hold_rd_data"}, bus.rd_data_o, v.e_rd);
            chk({p, "hold_in_ready"}, bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({p, "popped"}, bus.out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        //           ld st jm br sz uns addr          rs2           rdata        gnt hold lat req maddr        be       wdata         rd            mis err
        vecs[0]  = '{0, 0, 0, 0, 2, 0, 32'h00001234, 32'h0,       32'h0,        0, 0,  1,  0, 32'h0,   4'b0000, 32'h0,       32'h0,        0, 0};
        vecs[1]  = '{0, 0, 0, 1, 2, 0, 32'h00000040, 32'h0,       32'h0,        0, 0,  1,  0, 32'h0,   4'b0000, 32'h0,       32'h0,        0, 0};
        vecs[2]  = '{1, 0, 0, 0, 0, 0, 32'h00000103, 32'h0,       32'h80FFFF7F, 0, 0,  3,  1, 32'h100, 4'b1000, 32'h0,       32'hFFFFFF80, 0, 0};
        vecs[3]  = '{1, 0, 0, 0, 0, 1, 32'h00000103, 32'h0,       32'h80FFFF7F, 0, 0,  3,  1, 32'h100, 4'b1000, 32'h0,       32'h00000080, 0, 0};
        vecs[4]  = '{0, 1, 0, 0, 1, 0, 32'h00000102, 32'hABCD1234, 32'h0,       2, 0,  4,  3, 32'h100, 4'b1100, 32'h12340000, 32'h0,       0, 0};
        vecs[5]  = '{1, 0, 0, 0, 2, 0, 32'h00000101, 32'h0,       32'h0,        0, 0,  1,  0, 32'h0,   4'b0000, 32'h0,       32'h0,        1, 0};
        vecs[6]  = '{1, 0, 0, 0, 1, 0, 32'h00000102, 32'h0,       32'h80017FFF, 1, 0,  4,  2, 32'h100, 4'b1100, 32'h0,       32'hFFFF8001, 0, 0};
        vecs[7]  = '{1, 0, 0, 0, 1, 1, 32'h00000100, 32'h0,       32'h12348765, 0, 0,  3,  1, 32'h100, 4'b0011, 32'h0,       32'h00008765, 0, 0};
        vecs[8]  = '{0, 1, 0, 0, 0, 0, 32'h00000101, 32'h000000AB, 32'h0,       0, 0,  2,  1, 32'h100, 4'b0010, 32'h0000AB00, 32'h0,       0, 0};
        vecs[9]  = '{0, 1, 0, 0, 2, 0, 32'h00000200, 32'hDEADBEEF, 32'h0,       0, 0,  2,  1, 32'h200, 4'b1111, 32'hDEADBEEF, 32'h0,       0, 0};
        vecs[10] = '{1, 0, 0, 0, 2, 0, 32'h00000204, 32'h0,       32'hCAFEF00D, 0, 3,  3,  1, 32'h204, 4'b1111, 32'h0,       32'hCAFEF00D, 0, 0};
        vecs[11] = '{0, 1, 0, 0, 1, 0, 32'h00000103, 32'h5555AAAA, 32'h0,       0, 0,  1,  0, 32'h0,   4'b0000, 32'h0,       32'h0,        1, 0};
        vecs[12] = '{1, 0, 0, 0, 2, 0, 32'h00000300, 32'h0,       32'h12345678, -1, 0, 17, 16, 32'h300, 4'b1111, 32'h0,      32'h0,        0, 1};
        vecs[13] = '{0, 0, 1, 0, 2, 0, 32'h00000088, 32'h0,       32'h0,        0, 0,  1,  0, 32'h0,   4'b0000, 32'h0,       32'h0,        0, 0};
        vecs[14] = '{1, 0, 0, 0, 0, 0, 32'h00000100, 32'h0,       32'h0000007F, 0, 0,  3,  1, 32'h100, 4'b0001, 32'h0,       32'h0000007F, 0, 0};

        bus.in_valid = 1'b0; bus.pc_i = '0; bus.rd_i = '0; bus.alu_result_i = '0;
        bus.rs2_data_i = '0; bus.instr_ld_i = 1'b0; bus.instr_st_i = 1'b0;
        bus.instr_jm_i = 1'b0; bus.instr_br_i = 1'b0; bus.mem_size_i = 2'd0;
        bus.mem_unsigned_i = 1'b0; bus.out_ready = 1'b0; bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_flags", {bus.misalign_o, bus.bus_err_o}, 0);
        chk("rst_rd_data", bus.rd_data_o, 0);
        chk("rst_alu_result", bus.alu_result_o, 0);
        chk("rst_mem_bus", {bus.mem_addr, bus.mem_be, bus.mem_we, bus.mem_wdata}, 0);

        for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

        // Back-to-back issue: misaligned load then an ALU op accepted from OUT.
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.instr_ld_i = 1'b1; bus.instr_st_i = 1'b0;
        bus.instr_jm_i = 1'b0; bus.instr_br_i = 1'b0;
        bus.mem_size_i = 2'd2; bus.alu_result_i = 32'h101;
        @(negedge clk);
        chk("b2b_first_valid", bus.out_valid, 1);
        chk("b2b_first_mis", bus.misalign_o, 1);
        chk("b2b_in_ready_out", bus.in_ready, 1);
        bus.instr_ld_i = 1'b0; bus.alu_result_i = 32'h22;
        @(negedge clk);
        chk("b2b_second_valid", bus.out_valid, 1);
        chk("b2b_mis_cleared", bus.misalign_o, 0);
        chk("b2b_second_alu", bus.alu_result_o, 32'h22);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_idle_valid", bus.out_valid, 0);
        chk("b2b_idle_ready", bus.in_ready, 1);

        // Reset while waiting for read data; later rvalid must be ignored.
        bus.in_valid = 1'b1; bus.instr_ld_i = 1'b1; bus.mem_size_i = 2'd2;
        bus.alu_result_i = 32'h400; bus.pc_i = 32'h4444;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("rsp_rst_req", bus.mem_req, 1);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        chk("rsp_rst_req_drop", bus.mem_req, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rsp_rst_out_valid", bus.out_valid, 0);
        chk("rsp_rst_mem_req", bus.mem_req, 0);
        chk("rsp_rst_regs", {bus.alu_result_o, bus.pc_o, bus.instr_ld_o}, 0);
        chk("rsp_rst_rd_data", bus.rd_data_o, 0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFFFFFF; bus.instr_ld_i = 1'b0;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        chk("late_rvalid_valid", bus.out_valid, 0);
        chk("late_rvalid_data", bus.rd_data_o, 0);
        @(negedge clk);
        chk("late_rvalid_valid2", bus.out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
